// File: rtl/tlink_uncached_manager.sv
// Single-beat uncached TileLink manager: terminates Acquire/Grant/Finish in front of a word
// memory. Acquire/Grant/Finish channels are flattened into acq_*/gnt_*/fin_* port groups.
module tlink_uncached_manager #(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned MAX_XACT     = 4,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned NODE_W       = 2,
    parameter int unsigned CLIENT_XID_W = 4,
    parameter int unsigned MGR_XID_W    = 2,
    parameter int unsigned SUBBLOCK_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    // Acquire channel (inbound)
    input  logic                    acq_valid_i,
    output logic                    acq_ready_o,
    input  logic [NODE_W-1:0]       acq_src_i,
    input  logic [NODE_W-1:0]       acq_dst_i,
    input  logic [ADDR_W-1:0]       acq_addr_i,
    input  logic [CLIENT_XID_W-1:0] acq_client_xact_id_i,
    input  logic [DATA_W-1:0]       acq_data_i,
    input  logic [2:0]              acq_a_type_i,
    input  logic [SUBBLOCK_W-1:0]   acq_subblock_i,
    // Grant channel (outbound)
    output logic                    gnt_valid_o,
    input  logic                    gnt_ready_i,
    output logic [NODE_W-1:0]       gnt_src_o,
    output logic [NODE_W-1:0]       gnt_dst_o,
    output logic [CLIENT_XID_W-1:0] gnt_client_xact_id_o,
    output logic [MGR_XID_W-1:0]    gnt_manager_xact_id_o,
    output logic [DATA_W-1:0]       gnt_data_o,
    output logic [2:0]              gnt_g_type_o,
    // Finish channel (inbound)
    input  logic                    fin_valid_i,
    output logic                    fin_ready_o,
    input  logic [MGR_XID_W-1:0]    fin_manager_xact_id_i,
    // Error pulses
    output logic                    err_type,
    output logic                    err_finish
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    localparam logic [2:0] AcqUncachedRead   = 3'd0;
    localparam logic [2:0] AcqUncachedWrite  = 3'd1;
    localparam logic [2:0] AcqUncachedAtomic = 3'd2;
    localparam logic [2:0] GntUncachedRead   = 3'd0;
    localparam logic [2:0] GntUncachedWrite  = 3'd1;
    localparam logic [2:0] GntUncachedAtomic = 3'd2;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e                    state_q;
    logic                      rdy_q;
    logic [MAX_XACT-1:0]       trk_q, trk_d;
    logic [NODE_W-1:0]         gnt_src_q, gnt_dst_q;
    logic [CLIENT_XID_W-1:0]   gnt_cxid_q;
    logic [MGR_XID_W-1:0]      gnt_mxid_q;
    logic [DATA_W-1:0]         gnt_data_q;
    logic [2:0]                gnt_g_type_q;
    logic                      err_type_q, err_finish_q;
    logic [DATA_W-1:0]         mem_q [DEPTH];

    logic                      any_free;
    logic [MGR_XID_W-1:0]      alloc_idx;
    logic                      acq_fire, fin_fire, fin_hit;
    logic                      type_ok, mem_wr;
    logic [IDX_W-1:0]          idx;
    logic [DATA_W-1:0]         rsp_data;
    logic [2:0]                rsp_g_type;

    logic unused_acq;
    assign unused_acq = ^{acq_subblock_i, acq_addr_i[ADDR_W-1:IDX_W]};

    assign idx      = acq_addr_i[IDX_W-1:0];
    assign acq_fire = acq_valid_i && acq_ready_o;
    assign fin_fire = fin_valid_i && fin_ready_o;

    // Lowest-index free tracker; allocation looks only at the current state, so a slot being
    // freed by a concurrent Finish is never reused in the same cycle.
    always_comb begin
        any_free  = 1'b0;
        alloc_idx = '0;
        for (int i = 0; i < int'(MAX_XACT); i++) begin
            if (!trk_q[i] && !any_free) begin
                any_free  = 1'b1;
                alloc_idx = MGR_XID_W'(i);
            end
        end
    end

    always_comb begin
        fin_hit = 1'b0;
        trk_d   = trk_q;
        for (int i = 0; i < int'(MAX_XACT); i++) begin
            if (fin_fire && fin_manager_xact_id_i == MGR_XID_W'(i) && trk_q[i]) begin
                fin_hit  = 1'b1;
                trk_d[i] = 1'b0;
            end
            if (acq_fire && alloc_idx == MGR_XID_W'(i)) begin
                trk_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        type_ok    = 1'b1;
        mem_wr     = 1'b0;
        rsp_data   = '0;
        rsp_g_type = GntUncachedRead;
        unique case (acq_a_type_i)
            AcqUncachedRead: begin
                rsp_data = mem_q[idx];
            end
            AcqUncachedWrite: begin
                mem_wr     = 1'b1;
                rsp_g_type = GntUncachedWrite;
            end
            AcqUncachedAtomic: begin
                mem_wr     = 1'b1;
                rsp_data   = mem_q[idx];
                rsp_g_type = GntUncachedAtomic;
            end
            default: begin
                type_ok = 1'b0;
            end
        endcase
    end

    assign acq_ready_o           = rdy_q && (state_q == StIdle) && any_free;
    assign fin_ready_o           = rdy_q;
    assign gnt_valid_o           = (state_q == StGrant);
    assign gnt_src_o             = gnt_src_q;
    assign gnt_dst_o             = gnt_dst_q;
    assign gnt_client_xact_id_o  = gnt_cxid_q;
    assign gnt_manager_xact_id_o = gnt_mxid_q;
    assign gnt_data_o            = gnt_data_q;
    assign gnt_g_type_o          = gnt_g_type_q;
    assign err_type              = err_type_q;
    assign err_finish            = err_finish_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            rdy_q        <= 1'b0;
            trk_q        <= '0;
            gnt_src_q    <= '0;
            gnt_dst_q    <= '0;
            gnt_cxid_q   <= '0;
            gnt_mxid_q   <= '0;
            gnt_data_q   <= '0;
            gnt_g_type_q <= '0;
            err_type_q   <= 1'b0;
            err_finish_q <= 1'b0;
        end else begin
            rdy_q        <= 1'b1;
            trk_q        <= trk_d;
            err_type_q   <= acq_fire && !type_ok;
            err_finish_q <= fin_fire && !fin_hit;
            unique case (state_q)
                StIdle: begin
                    if (acq_fire) begin
                        state_q      <= StGrant;
                        gnt_src_q    <= acq_dst_i;
                        gnt_dst_q    <= acq_src_i;
                        gnt_cxid_q   <= acq_client_xact_id_i;
                        gnt_mxid_q   <= alloc_idx;
                        gnt_data_q   <= rsp_data;
                        gnt_g_type_q <= rsp_g_type;
                    end
                end
                StGrant: begin
                    if (gnt_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Backing store is deliberately not reset; writes are gated by acq_ready, which is low in reset.
    always_ff @(posedge clk) begin
        if (acq_fire && mem_wr) begin
            mem_q[idx] <= acq_data_i;
        end
    end

endmodule

// File: tb/tb_tlink_uncached_manager.sv
// Directed bench for tlink_uncached_manager: stimulus pushes expected Grants into a queue that a
// forked monitor pops and compares on every Grant handshake.
module tb_tlink_uncached_manager;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        acq_valid = 1'b0;
    logic        acq_ready;
    logic [1:0]  acq_src = 2'd1;
    logic [1:0]  acq_dst = 2'd2;
    logic [31:0] acq_addr = '0;
    logic [3:0]  acq_cxid = '0;
    logic [31:0] acq_data = '0;
    logic [2:0]  acq_a_type = '0;
    logic [3:0]  acq_subblock = '0;
    logic        gnt_valid;
    logic        gnt_ready = 1'b1;
    logic [1:0]  gnt_src, gnt_dst;
    logic [3:0]  gnt_cxid;
    logic [1:0]  gnt_mxid;
    logic [31:0] gnt_data;
    logic [2:0]  gnt_g_type;
    logic        fin_valid = 1'b0;
    logic        fin_ready;
    logic [1:0]  fin_id = '0;
    logic        err_type, err_finish;

    typedef logic [44:0] gvec_t;
    gvec_t exp_q[$];
    int    total = 0;
    int    bad = 0;

    always #5 clk = ~clk;

    tlink_uncached_manager dut (
        .clk                   (clk),
        .rst                   (rst),
        .acq_valid_i           (acq_valid),
        .acq_ready_o           (acq_ready),
        .acq_src_i             (acq_src),
        .acq_dst_i             (acq_dst),
        .acq_addr_i            (acq_addr),
        .acq_client_xact_id_i  (acq_cxid),
        .acq_data_i            (acq_data),
        .acq_a_type_i          (acq_a_type),
        .acq_subblock_i        (acq_subblock),
        .gnt_valid_o           (gnt_valid),
        .gnt_ready_i           (gnt_ready),
        .gnt_src_o             (gnt_src),
        .gnt_dst_o             (gnt_dst),
        .gnt_client_xact_id_o  (gnt_cxid),
        .gnt_manager_xact_id_o (gnt_mxid),
        .gnt_data_o            (gnt_data),
        .gnt_g_type_o          (gnt_g_type),
        .fin_valid_i           (fin_valid),
        .fin_ready_o           (fin_ready),
        .fin_manager_xact_id_i (fin_id),
        .err_type              (err_type),
        .err_finish            (err_finish)
    );

    function automatic gvec_t gnt_now();
        return {gnt_src, gnt_dst, gnt_cxid, gnt_mxid, gnt_data, gnt_g_type};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts just after a rising edge; returns at the negedge following acceptance.
    task automatic do_acq(input logic [2:0] at, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] cxid, input logic [31:0] edata, input logic [2:0] eg,
                          input logic [1:0] emx, input bit push);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        acq_a_type = at;
        acq_addr   = addr;
        acq_data   = data;
        acq_cxid   = cxid;
        acq_valid  = 1'b1;
        @(negedge clk);
        while (!acq_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!acq_ready) begin
            total++;
            bad++;
            $display("FAIL acq_timeout: got ready=0 expected ready=1 within 50 cycles");
            acq_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) exp_q.push_back({acq_dst, acq_src, cxid, emx, edata, eg});
        #1;
        acq_valid = 1'b0;
        @(negedge clk);
        chk("gnt_latency", 64'(gnt_valid), 64'd1);
        chk("err_type_on_accept", 64'(err_type), 64'(at > 3'd2));
    endtask

    task automatic do_fin(input logic [1:0] id);
        @(posedge clk);
        #1;
        fin_id    = id;
        fin_valid = 1'b1;
        @(negedge clk);
        chk("fin_ready", 64'(fin_ready), 64'd1);
        @(posedge clk);
        #1;
        fin_valid = 1'b0;
    endtask

    initial begin
        gvec_t snap;
        int    w;

        fork
            forever begin
                @(negedge clk);
                if (gnt_valid && gnt_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL grant_unexpected: got %0h expected no grant", gnt_now());
                    end else begin
                        chk("grant", 64'(gnt_now()), 64'(exp_q.pop_front()));
                    end
                end
            end
        join_none

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_acq_ready", 64'(acq_ready), 64'd0);
        chk("rst_gnt_valid", 64'(gnt_valid), 64'd0);
        chk("rst_fin_ready", 64'(fin_ready), 64'd0);
        chk("rst_gnt_fields", 64'(gnt_now()), 64'd0);
        chk("rst_errs", 64'({err_type, err_finish}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("acq_ready_release_cycle", 64'(acq_ready), 64'd0);
        @(negedge clk);
        chk("acq_ready_after_release", 64'(acq_ready), 64'd1);
        chk("fin_ready_after_release", 64'(fin_ready), 64'd1);

        // Write then read back
        do_acq(3'd1, 32'h10, 32'hDEADBEEF, 4'd3, 32'h0, 3'd1, 2'd0, 1'b1);
        do_fin(2'd0);
        do_acq(3'd0, 32'h10, 32'h0, 4'd4, 32'hDEADBEEF, 3'd0, 2'd0, 1'b1);
        do_fin(2'd0);

        // Atomic swap
        do_acq(3'd1, 32'h20, 32'hA, 4'd5, 32'h0, 3'd1, 2'd0, 1'b1);
        do_fin(2'd0);
        do_acq(3'd2, 32'h20, 32'h5, 4'd6, 32'hA, 3'd2, 2'd0, 1'b1);
        do_fin(2'd0);
        do_acq(3'd0, 32'h20, 32'h0, 4'd7, 32'h5, 3'd0, 2'd0, 1'b1);
        do_fin(2'd0);

        // Upper address bits alias onto the same word
        do_acq(3'd1, 32'h110, 32'h1234_5678, 4'd8, 32'h0, 3'd1, 2'd0, 1'b1);
        do_fin(2'd0);
        do_acq(3'd0, 32'h10, 32'h0, 4'd9, 32'h1234_5678, 3'd0, 2'd0, 1'b1);
        do_fin(2'd0);

        // Fill all trackers
        for (int i = 0; i < 4; i++) begin
            do_acq(3'd1, 32'h30 + 32'(i), 32'h100 + 32'(i), 4'(i), 32'h0, 3'd1, 2'(i), 1'b1);
        end
        @(negedge clk);
        chk("full_acq_ready", 64'(acq_ready), 64'd0);
        @(posedge clk);
        #1;
        fin_id    = 2'd2;
        fin_valid = 1'b1;
        @(negedge clk);
        chk("no_bypass_acq_ready", 64'(acq_ready), 64'd0);
        @(posedge clk);
        #1 fin_valid = 1'b0;
        @(negedge clk);
        chk("freed_acq_ready", 64'(acq_ready), 64'd1);
        do_acq(3'd0, 32'h31, 32'h0, 4'd10, 32'h101, 3'd0, 2'd2, 1'b1);
        for (int i = 0; i < 4; i++) do_fin(2'(i));

        // Finish concurrent with Acquire: the freed slot is not reused that cycle
        do_acq(3'd0, 32'h32, 32'h0, 4'd11, 32'h102, 3'd0, 2'd0, 1'b1);
        fork
            do_acq(3'd0, 32'h33, 32'h0, 4'd12, 32'h103, 3'd0, 2'd1, 1'b1);
            begin
                @(posedge clk);
                #1;
                fin_id    = 2'd0;
                fin_valid = 1'b1;
                @(posedge clk);
                #1 fin_valid = 1'b0;
            end
        join
        @(negedge clk);
        chk("concurrent_fin_no_err", 64'(err_finish), 64'd0);
        do_fin(2'd1);

        // Grant back-pressure
        gnt_ready = 1'b0;
        do_acq(3'd0, 32'h20, 32'h0, 4'd13, 32'h5, 3'd0, 2'd0, 1'b1);
        snap = gnt_now();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(gnt_valid), 64'd1);
            chk("hold_stable", 64'(gnt_now()), 64'(snap));
            chk("hold_acq_ready", 64'(acq_ready), 64'd0);
        end
        @(posedge clk);
        #1 gnt_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_idle_valid", 64'(gnt_valid), 64'd0);
        chk("release_idle_ready", 64'(acq_ready), 64'd1);
        do_fin(2'd0);

        // Finish with nothing pending
        do_fin(2'd1);
        @(negedge clk);
        chk("err_finish_pulse", 64'(err_finish), 64'd1);
        @(negedge clk);
        chk("err_finish_clear", 64'(err_finish), 64'd0);

        // Unrecognised a_type: no memory write, Grant data 0, read-type Grant
        do_acq(3'd5, 32'h20, 32'hFFFF_FFFF, 4'd14, 32'h0, 3'd0, 2'd0, 1'b1);
        @(negedge clk);
        chk("err_type_clear", 64'(err_type), 64'd0);
        do_fin(2'd0);
        do_acq(3'd0, 32'h20, 32'h0, 4'd15, 32'h5, 3'd0, 2'd0, 1'b1);
        do_fin(2'd0);

        // Reset during GRANT
        gnt_ready = 1'b0;
        do_acq(3'd1, 32'h40, 32'h77, 4'd2, 32'h0, 3'd1, 2'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_gnt_valid", 64'(gnt_valid), 64'd0);
        chk("rst_mid_acq_ready", 64'(acq_ready), 64'd0);
        chk("rst_mid_fin_ready", 64'(fin_ready), 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        gnt_ready = 1'b1;
        do_acq(3'd0, 32'h40, 32'h0, 4'd1, 32'h77, 3'd0, 2'd0, 1'b1);
        do_fin(2'd0);

        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            w++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL grants_outstanding: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
